pipeline_latch_ctrl: RTL and testbench

Hazard and stall controller for the processor pipeline. It drives the enable and clear inputs of the four inter-stage latch banks (FD, DX, XM, MW), which are built from negedge flip-flops, and the PC register enable. It handles load-use stalls, branch flushes, multicycle mult/div waits with a watchdog, and an external freeze request from the game/IO side.

---
 rtl/pipeline_latch_ctrl_pkg.sv | 24 ++
 rtl/pipeline_latch_ctrl_if.sv | 28 ++
 rtl/pipeline_latch_ctrl_md_watchdog.sv | 28 ++
 rtl/pipeline_latch_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_latch_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_latch_ctrl_pkg.sv
// Shared encodings for the pipeline latch/hazard controller: FSM states,
// return-state flag, latch bank indices and the default mult/div watchdog limit.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      FREEZE  = 2'd2,
      ERR     = 2'd3
   } pipe_state_e;

   typedef enum logic {
      RET_RUN = 1'b0,
      RET_MD  = 1'b1
   } ret_state_e;

   localparam int STG_FD = 0;
   localparam int STG_DX = 1;
   localparam int STG_XM = 2;
   localparam int STG_MW = 3;

   localparam int MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/pipeline_latch_ctrl_if.sv
// Hazard inputs and latch-bank control outputs of the pipeline controller.
// master = the controller, slave = the datapath/latch side.
interface pipeline_latch_ctrl_if #(
   parameter int NUM_STAGES = 4
);
   logic                  ld_use_hazard;
   logic                  branch_taken;
   logic                  md_start;
   logic                  md_ready;
   logic                  freeze_req;
   logic                  pc_ena;
   logic [NUM_STAGES-1:0] latch_ena;
   logic [NUM_STAGES-1:0] latch_clr;
   logic                  md_busy;
   logic                  md_timeout;
   logic [1:0]            state_o;
   logic [31:0]           stall_cycles;

   modport master (
      input  ld_use_hazard, branch_taken, md_start, md_ready, freeze_req,
      output pc_ena, latch_ena, latch_clr, md_busy, md_timeout, state_o, stall_cycles
   );

   modport slave (
      output ld_use_hazard, branch_taken, md_start, md_ready, freeze_req,
      input  pc_ena, latch_ena, latch_clr, md_busy, md_timeout, state_o, stall_cycles
   );
endinterface

// File: rtl/pipeline_latch_ctrl_md_watchdog.sv
// Mult/div wait watchdog: cycle counter cleared by start, advanced by run
// unless held, with expiry flag at MD_TIMEOUT-1.
module md_watchdog #(
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             run,
   input  logic             hold,
   output logic [CNT_W-1:0] cnt,
   output logic             expired
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (run && !hold) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == CNT_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_latch_ctrl.sv
// Hazard/stall controller driving the FD/DX/XM/MW latch enables/clears and PC enable.
// Optional PIPE_STALL_COUNT_EN adds a saturating stall-cycle counter on stall_cycles.
module pipeline_latch_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
   parameter int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
   input  logic                  clk,
   input  logic                  clr,
   pipeline_latch_ctrl_if.master bus
);

   pipe_state_e           state, state_nxt;
   ret_state_e            ret_state, ret_nxt;
   logic                  md_done_pend, pend_nxt;
   logic                  md_timeout_q;
   logic                  wd_start, wd_run, wd_expired;
   logic [CNT_W-1:0]      md_cnt;
   logic [NUM_STAGES-1:0] ena_c, clr_c;
   logic                  pc_c;
   logic                  pc_ena;

   md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) u_wd (
      .clk     (clk),
      .clr     (clr),
      .start   (wd_start),
      .run     (wd_run),
      .hold    (state == FREEZE),
      .cnt     (md_cnt),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state        <= RUN;
         ret_state    <= RET_RUN;
         md_done_pend <= 1'b0;
         md_timeout_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         ret_state    <= ret_nxt;
         md_done_pend <= pend_nxt;
         md_timeout_q <= md_timeout_q | (state_nxt == ERR);
      end
   end

   always_comb begin
      ena_c     = '1;
      clr_c     = '0;
      pc_c      = 1'b1;
      state_nxt = state;
      ret_nxt   = ret_state;
      pend_nxt  = md_done_pend;
      wd_start  = 1'b0;
      wd_run    = 1'b0;
      unique case (state)
         RUN: begin
            if (bus.freeze_req) begin
               ena_c     = '0;
               pc_c      = 1'b0;
               state_nxt = FREEZE;
               ret_nxt   = RET_RUN;
            end else if (bus.branch_taken || bus.md_start) begin
               // A taken branch flushes FD/DX even when a mult/div op starts in X.
               clr_c[STG_FD] = bus.branch_taken;
               clr_c[STG_DX] = bus.branch_taken;
               if (bus.md_start) begin
                  state_nxt = MD_WAIT;
                  wd_start  = 1'b1;
                  pend_nxt  = 1'b0;
               end
            end else if (bus.ld_use_hazard) begin
               pc_c          = 1'b0;
               ena_c[STG_FD] = 1'b0;
               clr_c[STG_DX] = 1'b1;
            end
         end
         MD_WAIT: begin
            if (bus.freeze_req) begin
               ena_c     = '0;
               pc_c      = 1'b0;
               state_nxt = FREEZE;
               ret_nxt   = RET_MD;
               pend_nxt  = md_done_pend | bus.md_ready;
            end else if (bus.md_ready) begin
               state_nxt = RUN;
            end else begin
               pc_c          = 1'b0;
               ena_c[STG_FD] = 1'b0;
               ena_c[STG_DX] = 1'b0;
               clr_c[STG_XM] = 1'b1;
               ena_c[STG_MW] = 1'b1;
               wd_run        = 1'b1;
               if (wd_expired) state_nxt = ERR;
            end
         end
         FREEZE: begin
            ena_c    = '0;
            pc_c     = 1'b0;
            pend_nxt = md_done_pend | bus.md_ready;
            if (!bus.freeze_req) begin
               // Completion seen while frozen: release as the MD_WAIT ready cycle.
               if (ret_state == RET_MD && (md_done_pend || bus.md_ready)) begin
                  ena_c     = '1;
                  pc_c      = 1'b1;
                  state_nxt = RUN;
                  pend_nxt  = 1'b0;
               end else begin
                  state_nxt = (ret_state == RET_MD) ? MD_WAIT : RUN;
               end
            end
         end
         default: begin
            ena_c = '0;
            pc_c  = 1'b0;
         end
      endcase
   end

   assign pc_ena         = clr ? 1'b0 : pc_c;
   assign bus.pc_ena     = pc_ena;
   assign bus.latch_ena  = clr ? '0 : ena_c;
   assign bus.latch_clr  = clr ? '1 : clr_c;
   assign bus.md_busy    = (state == MD_WAIT) || (state == FREEZE && ret_state == RET_MD);
   assign bus.md_timeout = md_timeout_q;
   assign bus.state_o    = state;

`ifdef PIPE_STALL_COUNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         stall_q <= '0;
      end else if (!pc_ena && state != ERR && stall_q != 32'hFFFF_FFFF) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
`else
   assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Self-checking bench for pipeline_latch_ctrl: directed hazard scenarios followed by
// randomized traffic, all checked against a behavioural model of the controller.
module tb_pipeline_latch_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   pipeline_latch_ctrl_if #(.NUM_STAGES(4)) bus ();

   pipeline_latch_ctrl #(.NUM_STAGES(4), .MD_TIMEOUT(40)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: "what the pipeline is doing" flags rather than a state code.
   bit m_err, m_frozen, m_in_md, m_done;
   int m_cnt;
   int unsigned m_stall;
   bit exp_pc_last;
   int obs_state;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_err = 0; m_frozen = 0; m_in_md = 0; m_done = 0; m_cnt = 0; m_stall = 0;
   endtask

   task automatic compare();
      logic [3:0] e_ena, e_clr;
      logic       e_pc;
      int         e_state;
      bit f, b, s, r, l;
      f = bus.freeze_req; b = bus.branch_taken; s = bus.md_start;
      r = bus.md_ready;   l = bus.ld_use_hazard;
      e_ena = 4'b1111; e_clr = 4'b0000; e_pc = 1'b1;
      if (clr) begin
         e_ena = 4'b0000; e_clr = 4'b1111; e_pc = 1'b0;
      end else if (m_err) begin
         e_ena = 4'b0000; e_pc = 1'b0;
      end else if (m_frozen) begin
         if (!(!f && m_in_md && (m_done || r))) begin
            e_ena = 4'b0000; e_pc = 1'b0;
         end
      end else if (m_in_md) begin
         if (f) begin
            e_ena = 4'b0000; e_pc = 1'b0;
         end else if (!r) begin
            e_ena = 4'b1100; e_clr = 4'b0100; e_pc = 1'b0;
         end
      end else begin
         if (f) begin
            e_ena = 4'b0000; e_pc = 1'b0;
         end else if (b) begin
            e_clr = 4'b0011;
         end else if (!s && l) begin
            e_ena = 4'b1110; e_clr = 4'b0010; e_pc = 1'b0;
         end
      end
      e_state = clr ? 0 : m_err ? 3 : m_frozen ? 2 : m_in_md ? 1 : 0;
      exp_pc_last = e_pc;
      obs_state = int'(bus.state_o);
      chk("pc_ena", 32'(bus.pc_ena), 32'(e_pc));
      chk("latch_ena", 32'(bus.latch_ena), 32'(e_ena));
      chk("latch_clr", 32'(bus.latch_clr), 32'(e_clr));
      chk("state", 32'(bus.state_o), 32'(e_state));
      chk("md_busy", 32'(bus.md_busy), 32'(!clr && !m_err && m_in_md));
      chk("md_timeout", 32'(bus.md_timeout), 32'(!clr && m_err));
`ifdef PIPE_STALL_COUNT_EN
      chk("stall_cycles", bus.stall_cycles, m_stall);
`else
      chk("stall_cycles", bus.stall_cycles, 32'd0);
`endif
   endtask

   task automatic model_update();
      bit f, s, r;
      f = bus.freeze_req; s = bus.md_start; r = bus.md_ready;
      if (!exp_pc_last && !m_err && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_err) begin
      end else if (m_frozen) begin
         if (r) m_done = 1;
         if (!f) begin
            m_frozen = 0;
            if (m_in_md && m_done) begin
               m_in_md = 0;
               m_done  = 0;
            end
         end
      end else if (m_in_md) begin
         if (f) begin
            m_frozen = 1;
            if (r) m_done = 1;
         end else if (r) begin
            m_in_md = 0;
         end else if (m_cnt == 40 - 1) begin
            m_err = 1;
         end else begin
            m_cnt++;
         end
      end else begin
         if (f) begin
            m_frozen = 1;
            m_done   = 0;
         end else if (s) begin
            m_in_md = 1; m_cnt = 0; m_done = 0;
         end
      end
   endtask

   // One clock: drive at negedge, check mid-cycle, advance the model at posedge.
   task automatic step(input bit c, input bit f, input bit b, input bit s, input bit r, input bit l);
      @(negedge clk);
      clr = c;
      bus.freeze_req = f; bus.branch_taken = b; bus.md_start = s;
      bus.md_ready = r;   bus.ld_use_hazard = l;
      if (c) model_reset();
      #1;
      compare();
      @(posedge clk);
      if (!c) model_update();
   endtask

   initial begin
      int n_wait;
      int err_age;
      bit f;
      bus.freeze_req = 0; bus.branch_taken = 0; bus.md_start = 0;
      bus.md_ready = 0;   bus.ld_use_hazard = 0;
      model_reset();
      exp_pc_last = 0;

      repeat (2) step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Load-use stall then recovery; branch with load-use.
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);

      // Mult/div with ready seven cycles later.
      step(0, 0, 0, 1, 0, 0);
      repeat (7) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // Freeze during MD_WAIT, ready while frozen, release later.
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Clear in the middle of MD_WAIT with ten cycles already counted.
      step(0, 0, 1, 1, 0, 0);
      repeat (10) step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Watchdog: exactly 40 MD_WAIT cycles before ERR, counter restarted by the clear.
      step(0, 0, 0, 1, 0, 0);
      n_wait = 0;
      for (int i = 0; i < 60; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (obs_state == 1) n_wait++;
         if (obs_state == 3) break;
      end
      chk("md_wait_len", 32'(n_wait), 32'd40);
      for (int i = 0; i < 5; i++)
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1, 0, 0, 0, 0, 0);

      // Randomized traffic.
      f = 0;
      err_age = 0;
      for (int i = 0; i < 4000; i++) begin
         bit c, b, s, r, l;
         if ($urandom_range(0, 11) == 0) f = ~f;
         err_age = m_err ? err_age + 1 : 0;
         c = ($urandom_range(0, 399) == 0) || (err_age > 6);
         b = ($urandom_range(0, 7) == 0);
         s = ($urandom_range(0, 5) == 0);
         r = m_in_md ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 29) == 0);
         l = ($urandom_range(0, 3) == 0);
         step(c, f, b, s, r, l);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
